// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation pixel feeder: default block
// sizes, the feeder FSM state encoding and a small constant helper.
// No ports; imported by pel_feeder and pel_addr_gen.
package me_pkg;

  localparam int TB_LENGTH_DEF = 8;
  localparam int SW_LENGTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_TB = 2'd1,
    ST_LOAD_SW = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  function automatic int max_len(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pel_feeder_if.sv
// Pixel memory read bus between the feeder and the pixel store.
// Signals: mem_rd (read strobe), mem_addr (read address), mem_rdata (data,
// valid the cycle after mem_rd). master = feeder side, slave = memory side.
interface pel_feeder_if #(
  parameter int ADDR_W = 16
);

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  modport master (output mem_rd, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata);

endinterface

// File: rtl/pel_addr_gen.sv
// Row/column counters and raster address generation for TB and SW loads.
// Ports: clk/rst; load captures tb_base/sw_base and restarts at the TB origin;
// step advances one pixel; sel_sw picks the SW geometry; addr is the current
// read address (modulo 2^ADDR_W); last flags the final pixel of the phase.
module pel_addr_gen
  import me_pkg::*;
#(
  parameter int TB_LENGTH = TB_LENGTH_DEF,
  parameter int SW_LENGTH = SW_LENGTH_DEF,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] tb_base,
  input  logic [ADDR_W-1:0] sw_base,
  input  logic              step,
  input  logic              sel_sw,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int CNT_W = $clog2(max_len(TB_LENGTH, SW_LENGTH)) + 1;
  localparam logic [CNT_W-1:0]  TB_MAX    = CNT_W'(TB_LENGTH - 1);
  localparam logic [CNT_W-1:0]  SW_MAX    = CNT_W'(SW_LENGTH - 1);
  localparam logic [ADDR_W-1:0] TB_STRIDE = ADDR_W'(TB_LENGTH);
  localparam logic [ADDR_W-1:0] SW_STRIDE = ADDR_W'(SW_LENGTH);

  logic [CNT_W-1:0]  row_q, col_q, len_max;
  logic [ADDR_W-1:0] row_addr_q, sw_base_q, stride;
  logic              row_end;

  // row_addr_q tracks base + r*LENGTH incrementally, so no multiplier is
  // needed; the sum simply wraps at 2^ADDR_W.
  always_comb begin
    len_max = sel_sw ? SW_MAX : TB_MAX;
    stride  = sel_sw ? SW_STRIDE : TB_STRIDE;
    row_end = (col_q == len_max);
    last    = row_end && (row_q == len_max);
    addr    = row_addr_q + ADDR_W'(col_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      col_q      <= '0;
      row_addr_q <= '0;
      sw_base_q  <= '0;
    end else if (load) begin
      row_q      <= '0;
      col_q      <= '0;
      row_addr_q <= tb_base;
      sw_base_q  <= sw_base;
    end else if (step) begin
      if (row_end) begin
        col_q <= '0;
        if (last) begin
          // End of a phase: counters restart and the SW origin is preloaded
          // so the first SW read follows the last TB read without a bubble.
          row_q      <= '0;
          row_addr_q <= sw_base_q;
        end else begin
          row_q      <= row_q + 1'b1;
          row_addr_q <= row_addr_q + stride;
        end
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pel_feeder.sv
// Streams one template block then one search window from pixel memory to the
// PE array. Ports: start/tb_base/sw_base request, hold stall, mem read bus,
// en_/pel_ tb and sw streams, busy/done status, stall_cnt.
// Optional stall counter enabled with macro PEL_FEEDER_STALL_CNT_EN.
module pel_feeder
  import me_pkg::*;
#(
  parameter int TB_LENGTH = TB_LENGTH_DEF,
  parameter int SW_LENGTH = SW_LENGTH_DEF,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] tb_base,
  input  logic [ADDR_W-1:0] sw_base,
  input  logic              hold,
  pel_feeder_if.master      mem,
  output logic              en_tb,
  output logic [7:0]        pel_tb,
  output logic              en_sw,
  output logic [7:0]        pel_sw,
  output logic              busy,
  output logic              done,
  output logic [15:0]       stall_cnt
);

  state_t            state_q, state_d;
  logic              accept, issue, last;
  logic              rd_q, sw_q;
  logic [ADDR_W-1:0] addr;

  assign accept = (state_q == ST_IDLE) && start;
  assign issue  = ((state_q == ST_LOAD_TB) || (state_q == ST_LOAD_SW)) && !hold;

  pel_addr_gen #(
    .TB_LENGTH (TB_LENGTH),
    .SW_LENGTH (SW_LENGTH),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .tb_base (tb_base),
    .sw_base (sw_base),
    .step    (issue),
    .sel_sw  (state_q == ST_LOAD_SW),
    .addr    (addr),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FLUSH waits for the final SW beat (rd_q high) and pulses done the cycle
  // after it.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_LOAD_TB;
      ST_LOAD_TB: if (issue && last) state_d = ST_LOAD_SW;
      ST_LOAD_SW: if (issue && last) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (!rd_q) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Memory data arrives one cycle after the strobe; remember which phase the
  // read belonged to. Reset clears rd_q, discarding any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= 1'b0;
      sw_q <= 1'b0;
    end else begin
      rd_q <= issue;
      sw_q <= (state_q == ST_LOAD_SW);
    end
  end

  assign mem.mem_rd   = issue;
  assign mem.mem_addr = issue ? addr : '0;

  assign en_tb  = rd_q && !sw_q;
  assign en_sw  = rd_q && sw_q;
  assign pel_tb = en_tb ? mem.mem_rdata : 8'h00;
  assign pel_sw = en_sw ? mem.mem_rdata : 8'h00;
  assign busy   = (state_q != ST_IDLE);

`ifdef PEL_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst || accept)                          stall_q <= '0;
    else if (busy && hold && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pel_feeder.sv
// Self-checking bench for pel_feeder: randomized bases, hold patterns and data
// against a raster-order reference model and a cycle-count timing model.
module tb_pel_feeder;

  logic        clk = 1'b0;
  logic        rst, start, hold;
  logic [15:0] tb_base, sw_base;
  logic        en_tb, en_sw, busy, done;
  logic [7:0]  pel_tb, pel_sw;
  logic [15:0] stall_cnt;

  pel_feeder_if #(.ADDR_W(16)) mem_if ();

  pel_feeder #(.TB_LENGTH(8), .SW_LENGTH(32), .ADDR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tb_base   (tb_base),
    .sw_base   (sw_base),
    .hold      (hold),
    .mem       (mem_if),
    .en_tb     (en_tb),
    .pel_tb    (pel_tb),
    .en_sw     (en_sw),
    .pel_sw    (pel_sw),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Memory model: one-cycle read latency, garbage on the bus otherwise.
  logic [7:0] dmask = 8'h00;
  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ (a[15:8] & dmask);
  endfunction

  always @(posedge clk) begin
    if (mem_if.mem_rd) mem_if.mem_rdata <= mem_fn(mem_if.mem_addr);
    else               mem_if.mem_rdata <= 8'($urandom);
  end

  // Monitor state, sampled on the falling edge.
  bit          mon_on = 1'b0;
  int          t0, rst_rel;
  logic [15:0] got_addr[$];
  logic [7:0]  tbq[$], swq[$];
  int          done_q[$];
  int          rd_first, rd_last, tb_first, tb_last, sw_first, sw_last;
  int          busy_first, busy_cnt, viol, post_rst_nz;

  always @(negedge clk) begin : mon_blk
    int rel;
    if (mon_on) begin
      rel = cyc - t0;
      if (mem_if.mem_rd) begin
        got_addr.push_back(mem_if.mem_addr);
        if (rd_first < 0) rd_first = rel;
        rd_last = rel;
      end
      if (en_tb) begin
        tbq.push_back(pel_tb);
        if (tb_first < 0) tb_first = rel;
        tb_last = rel;
      end
      if (en_sw) begin
        swq.push_back(pel_sw);
        if (sw_first < 0) sw_first = rel;
        sw_last = rel;
      end
      if (done) done_q.push_back(rel);
      if (busy) begin
        if (busy_first < 0) busy_first = rel;
        busy_cnt++;
      end
      if ((en_tb && en_sw) || (!en_tb && pel_tb != 8'h00) ||
          (!en_sw && pel_sw != 8'h00) || (!mem_if.mem_rd && mem_if.mem_addr != 16'h0))
        viol++;
      if (rel > rst_rel && (mem_if.mem_rd || en_tb || en_sw || busy || done ||
          pel_tb != 8'h00 || pel_sw != 8'h00 || mem_if.mem_addr != 16'h0 ||
          stall_cnt != 16'h0))
        post_rst_nz++;
    end
  end

  // Reference model: expected addresses and pixel streams in raster order.
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_tb[$], exp_sw[$];
  bit          plan[0:2047];

  task automatic build_model(input logic [15:0] tb_b, input logic [15:0] sw_b);
    logic [15:0] a;
    exp_addr.delete(); exp_tb.delete(); exp_sw.delete();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        a = tb_b + 16'(r * 8 + c);
        exp_addr.push_back(a);
        exp_tb.push_back(mem_fn(a));
      end
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) begin
        a = sw_b + 16'(r * 32 + c);
        exp_addr.push_back(a);
        exp_sw.push_back(mem_fn(a));
      end
  endtask

  // A read is issued in every busy load cycle with hold low; 1088 are needed,
  // and done follows two cycles after the last one.
  task automatic timing_model(output int d, output int st);
    int reads = 0;
    int l = -1;
    for (int k = 1; k < 2000 && l < 0; k++) begin
      if (!plan[k]) reads++;
      if (reads == 1088) l = k;
    end
    d  = l + 2;
    st = 0;
`ifdef PEL_FEEDER_STALL_CNT_EN
    for (int k = 1; k <= l + 2; k++) st += int'(plan[k]);
`endif
  endtask

  task automatic clear_plan();
    for (int k = 0; k < 2048; k++) plan[k] = 1'b0;
  endtask

  task automatic rand_plan();
    clear_plan();
    for (int k = 1; k < 2048; k++) plan[k] = ($urandom_range(0, 9) == 0);
  endtask

  function automatic int diff_addr();
    int n = 0;
    if (got_addr.size() != exp_addr.size()) n++;
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      if (got_addr[i] !== exp_addr[i]) n++;
    return n;
  endfunction

  function automatic int diff_tb();
    int n = 0;
    if (tbq.size() != exp_tb.size()) n++;
    for (int i = 0; i < tbq.size() && i < exp_tb.size(); i++)
      if (tbq[i] !== exp_tb[i]) n++;
    return n;
  endfunction

  function automatic int diff_sw();
    int n = 0;
    if (swq.size() != exp_sw.size()) n++;
    for (int i = 0; i < swq.size() && i < exp_sw.size(); i++)
      if (swq[i] !== exp_sw[i]) n++;
    return n;
  endfunction

  function automatic int done_at();
    return (done_q.size() > 0) ? done_q[0] : -1;
  endfunction

  // Drives one request; relative cycle 0 is the start cycle.
  task automatic run_op(input logic [15:0] tb_b, input logic [15:0] sw_b,
                        input int rst_at, input int extra_at, input int budget);
    got_addr.delete(); tbq.delete(); swq.delete(); done_q.delete();
    rd_first = -1; rd_last = -1; tb_first = -1; tb_last = -1;
    sw_first = -1; sw_last = -1; busy_first = -1; busy_cnt = 0;
    viol = 0; post_rst_nz = 0;
    rst_rel = (rst_at >= 0) ? rst_at : 32'h3FFF_FFFF;
    @(posedge clk); #1;
    start = 1'b1; tb_base = tb_b; sw_base = sw_b; hold = plan[0]; rst = 1'b0;
    t0 = cyc; mon_on = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      hold  = plan[k];
      rst   = (k == rst_at);
      if (k == extra_at) begin
        start   = 1'b1;
        tb_base = 16'($urandom);
        sw_base = 16'($urandom);
      end
      if (done_q.size() > 0 && k >= done_q[0] + 3) break;
    end
    @(negedge clk);
    mon_on = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hold = 1'b0; tb_base = '0; sw_base = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_if.mem_rd, en_tb, en_sw, busy, done} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000",
                         {mem_if.mem_rd, en_tb, en_sw, busy, done});
    end
    checks++;
    if ({pel_tb, pel_sw} !== 16'h0) begin
      errors++; $display("FAIL reset_pel: got %h want 0000", {pel_tb, pel_sw});
    end
    checks++;
    if (mem_if.mem_addr !== 16'h0) begin
      errors++; $display("FAIL reset_addr: got %h want 0000", mem_if.mem_addr);
    end
    checks++;
    if (stall_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_nominal();
    int d, st;
    logic [7:0] v0, v32;
    dmask = 8'h00;
    clear_plan();
    build_model(16'h0100, 16'h1000);
    timing_model(d, st);
    run_op(16'h0100, 16'h1000, -1, -1, 1200);
    v0 = 'x; v32 = 'x;
    if (swq.size() > 0)  v0 = swq[0];
    if (swq.size() > 32) v32 = swq[32];
    checks++; if (rd_first !== 1) begin errors++; $display("FAIL nom_rd_first: got %0d want 1", rd_first); end
    checks++; if (rd_last !== 1088) begin errors++; $display("FAIL nom_rd_last: got %0d want 1088", rd_last); end
    checks++; if (got_addr.size() !== 1088) begin errors++; $display("FAIL nom_rd_count: got %0d want 1088", got_addr.size()); end
    checks++; if (tb_first !== 2 || tb_last !== 65) begin errors++; $display("FAIL nom_en_tb_window: got %0d..%0d want 2..65", tb_first, tb_last); end
    checks++; if (sw_first !== 66 || sw_last !== 1089) begin errors++; $display("FAIL nom_en_sw_window: got %0d..%0d want 66..1089", sw_first, sw_last); end
    checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL nom_done_count: got %0d want 1", done_q.size()); end
    checks++; if (done_at() !== 1090) begin errors++; $display("FAIL nom_done_cycle: got %0d want 1090", done_at()); end
    checks++; if (diff_addr() !== 0) begin errors++; $display("FAIL nom_addr: %0d address mismatches, want 0", diff_addr()); end
    checks++; if (diff_tb() !== 0) begin errors++; $display("FAIL nom_pel_tb: %0d beat mismatches, want 0", diff_tb()); end
    checks++; if (diff_sw() !== 0) begin errors++; $display("FAIL nom_pel_sw: %0d beat mismatches, want 0", diff_sw()); end
    checks++; if (v0 !== 8'h00) begin errors++; $display("FAIL nom_sw_first: got %h want 00", v0); end
    checks++; if (v32 !== 8'h20) begin errors++; $display("FAIL nom_sw_33rd: got %h want 20", v32); end
    checks++; if (busy_first !== 1 || busy_cnt !== 1090) begin errors++; $display("FAIL nom_busy: first %0d count %0d want 1 and 1090", busy_first, busy_cnt); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL nom_stream_rules: %0d violations want 0", viol); end
    checks++; if (stall_cnt !== 16'(st)) begin errors++; $display("FAIL nom_stall: got %0d want %0d", stall_cnt, st); end
  endtask

  task automatic test_hold5();
    int d, st, want_st;
    dmask = 8'($urandom);
    clear_plan();
    for (int k = 200; k < 205; k++) plan[k] = 1'b1;
    build_model(16'h2000, 16'h3000);
    timing_model(d, st);
`ifdef PEL_FEEDER_STALL_CNT_EN
    want_st = 5;
`else
    want_st = 0;
`endif
    run_op(16'h2000, 16'h3000, -1, -1, 1300);
    checks++; if (done_at() !== 1095) begin errors++; $display("FAIL hold5_done: got %0d want 1095", done_at()); end
    checks++; if (swq.size() !== 1024) begin errors++; $display("FAIL hold5_sw_beats: got %0d want 1024", swq.size()); end
    checks++; if (diff_sw() !== 0) begin errors++; $display("FAIL hold5_pel_sw: %0d mismatches want 0", diff_sw()); end
    checks++; if (diff_addr() !== 0) begin errors++; $display("FAIL hold5_addr: %0d mismatches want 0", diff_addr()); end
    checks++; if (stall_cnt !== 16'(want_st)) begin errors++; $display("FAIL hold5_stall: got %0d want %0d", stall_cnt, want_st); end
  endtask

  task automatic test_wrap();
    int d, st;
    logic [15:0] tb_b, a16;
    dmask = 8'($urandom);
    tb_b  = 16'($urandom);
    clear_plan();
    build_model(tb_b, 16'hFFF0);
    timing_model(d, st);
    run_op(tb_b, 16'hFFF0, -1, -1, 1200);
    a16 = 'x;
    if (got_addr.size() > 80) a16 = got_addr[80];
    checks++; if (a16 !== 16'h0000) begin errors++; $display("FAIL wrap_point: got %h want 0000", a16); end
    checks++; if (diff_addr() !== 0) begin errors++; $display("FAIL wrap_addr: %0d mismatches want 0", diff_addr()); end
    checks++; if (diff_tb() + diff_sw() !== 0) begin errors++; $display("FAIL wrap_pel: %0d mismatches want 0", diff_tb() + diff_sw()); end
    checks++; if (done_at() !== d) begin errors++; $display("FAIL wrap_done: got %0d want %0d", done_at(), d); end
  endtask

  task automatic test_random();
    int d, st;
    logic [15:0] tb_b, sw_b;
    for (int it = 0; it < 3; it++) begin
      dmask = 8'($urandom);
      tb_b  = 16'($urandom);
      sw_b  = 16'($urandom);
      rand_plan();
      build_model(tb_b, sw_b);
      timing_model(d, st);
      run_op(tb_b, sw_b, -1, -1, 1900);
      checks++; if (diff_addr() !== 0) begin errors++; $display("FAIL rand%0d_addr: %0d mismatches want 0", it, diff_addr()); end
      checks++; if (diff_tb() + diff_sw() !== 0) begin errors++; $display("FAIL rand%0d_pel: %0d mismatches want 0", it, diff_tb() + diff_sw()); end
      checks++; if (done_at() !== d || done_q.size() !== 1) begin errors++; $display("FAIL rand%0d_done: got cycle %0d count %0d want cycle %0d count 1", it, done_at(), done_q.size(), d); end
      checks++; if (busy_cnt !== d) begin errors++; $display("FAIL rand%0d_busy: got %0d cycles want %0d", it, busy_cnt, d); end
      checks++; if (viol !== 0) begin errors++; $display("FAIL rand%0d_stream_rules: %0d violations want 0", it, viol); end
      checks++; if (stall_cnt !== 16'(st)) begin errors++; $display("FAIL rand%0d_stall: got %0d want %0d", it, stall_cnt, st); end
    end
  endtask

  task automatic test_mid_reset();
    int d, st;
    logic [15:0] tb_b, sw_b, a0;
    dmask = 8'($urandom);
    tb_b  = 16'($urandom);
    sw_b  = 16'($urandom);
    clear_plan();
    run_op(tb_b, sw_b, 30, -1, 39);
    checks++; if (post_rst_nz !== 0) begin errors++; $display("FAIL mrst_outputs: %0d nonzero cycles after reset want 0", post_rst_nz); end
    checks++; if (tbq.size() !== 29) begin errors++; $display("FAIL mrst_beats: got %0d en_tb beats want 29", tbq.size()); end
    checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL mrst_done: got %0d pulses want 0", done_q.size()); end
    build_model(tb_b, sw_b);
    timing_model(d, st);
    run_op(tb_b, sw_b, -1, -1, 1200);
    a0 = 'x;
    if (got_addr.size() > 0) a0 = got_addr[0];
    checks++; if (a0 !== tb_b) begin errors++; $display("FAIL mrst_restart_addr: got %h want %h", a0, tb_b); end
    checks++; if (done_at() !== 1090) begin errors++; $display("FAIL mrst_restart_done: got %0d want 1090", done_at()); end
    checks++; if (diff_tb() + diff_sw() !== 0) begin errors++; $display("FAIL mrst_restart_pel: %0d mismatches want 0", diff_tb() + diff_sw()); end
  endtask

  task automatic test_start_while_busy();
    int d, st;
    int extra[2] = '{500, 1090};
    logic [15:0] tb_b, sw_b;
    for (int it = 0; it < 2; it++) begin
      dmask = 8'($urandom);
      tb_b  = 16'($urandom);
      sw_b  = 16'($urandom);
      clear_plan();
      build_model(tb_b, sw_b);
      timing_model(d, st);
      run_op(tb_b, sw_b, -1, extra[it], 1200);
      checks++; if (done_q.size() !== 1 || done_at() !== 1090) begin errors++; $display("FAIL busy_start%0d_done: got count %0d cycle %0d want 1 at 1090", it, done_q.size(), done_at()); end
      checks++; if (diff_addr() !== 0) begin errors++; $display("FAIL busy_start%0d_addr: %0d mismatches want 0", it, diff_addr()); end
      checks++; if (tbq.size() + swq.size() !== 1088) begin errors++; $display("FAIL busy_start%0d_beats: got %0d want 1088", it, tbq.size() + swq.size()); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; tb_base = '0; sw_base = '0;
    test_reset();
    test_nominal();
    test_hold5();
    test_wrap();
    test_random();
    test_mid_reset();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pel_feeder.md
PEL_FEEDER -- requirements
Module: pel_feeder

Interface
REQ-001 SHALL have parameter TB_LENGTH, default 8, template block edge in pixels.
REQ-002 SHALL have parameter SW_LENGTH, default 32, search window edge in pixels.
REQ-003 SHALL have parameter ADDR_W, default 16, pixel memory address width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to stream one TB and one SW.
REQ-007 SHALL have port tb_base  input  ADDR_W  TB base address, sampled with start.
REQ-008 SHALL have port sw_base  input  ADDR_W  SW base address, sampled with start.
REQ-009 SHALL have port hold  input  1  downstream stall; no new read is issued while high.
REQ-010 SHALL have port mem_rd  output  1  memory read strobe.
REQ-011 SHALL have port mem_addr  output  ADDR_W  memory read address.
REQ-012 SHALL have port mem_rdata  input  8  read data, valid exactly one cycle after mem_rd.
REQ-013 SHALL have ports en_tb output 1 and pel_tb output 8  template pixel stream to the PE array.
REQ-014 SHALL have ports en_sw output 1 and pel_sw output 8  search-window pixel stream to the PE array.
REQ-015 SHALL have ports busy output 1 and done output 1 (one-cycle completion pulse).
REQ-016 SHALL have port stall_cnt  output  16  count of hold cycles while busy.

Function
REQ-017 SHALL implement states IDLE, LOAD_TB, LOAD_SW, FLUSH.
REQ-018 SHALL leave IDLE for LOAD_TB when start=1 in IDLE, capturing tb_base/sw_base; start outside IDLE SHALL be ignored.
REQ-019 SHALL issue the first mem_rd in the cycle after start is sampled.
REQ-020 SHALL in LOAD_TB issue TB_LENGTH*TB_LENGTH reads, raster order, address tb_base + r*TB_LENGTH + c.
REQ-021 SHALL move to LOAD_SW with no bubble cycle; issue SW_LENGTH*SW_LENGTH reads at sw_base + r*SW_LENGTH + c.
REQ-022 SHALL compute addresses modulo 2^ADDR_W (wrap, no error).
REQ-023 SHALL, for every read issued, assert exactly one en_tb (TB phase) or en_sw (SW phase) one cycle later with pel = mem_rdata; en_tb and en_sw SHALL never be high together.
REQ-024 SHALL, while hold=1, deassert mem_rd and freeze counters; data of a read issued the previous cycle SHALL still be delivered.
REQ-025 SHALL enter FLUSH after the last SW read issue, pulse done in the cycle after the last en_sw, then return to IDLE.
REQ-026 SHALL with hold=0 throughout give exactly 1088 consecutive en beats (64 en_tb then 1024 en_sw) for default parameters.
REQ-027 SHALL hold busy=1 from the cycle after start is accepted through the done cycle inclusive.
REQ-028 SHALL drive pel_tb/pel_sw to 0 whenever the matching enable is 0.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, enter IDLE and drive mem_rd, en_tb, en_sw, busy, done to 0, pel_*/mem_addr to 0, stall_cnt to 0, from the next cycle.
REQ-030 SHALL on reset mid-operation discard any in-flight read data; no enable follows reset.

Configuration
REQ-031 SHALL, with macro PEL_FEEDER_STALL_CNT_EN defined, increment stall_cnt (saturating at 16'hFFFF) each cycle busy=1 and hold=1, clearing it on accepted start.
REQ-032 SHALL, with PEL_FEEDER_STALL_CNT_EN undefined, tie stall_cnt to 0 and infer no counter.

Structure
REQ-033 SHALL take TB_LENGTH/SW_LENGTH defaults and state encoding from shared package me_pkg.
REQ-034 SHALL place the row/column counters and address arithmetic in sub-module pel_addr_gen.

Verification
REQ-035 Scenario: tb_base=0x0100, sw_base=0x1000, hold=0, start at cycle 0 -> mem_rd cycles 1..1088, en_tb cycles 2..65, en_sw 66..1089, done at 1090.
REQ-036 Scenario: mem model returns addr[7:0] -> pel_tb sequence 0x00..0x3F, first pel_sw 0x00, 33rd pel_sw 0x20.
REQ-037 Scenario: hold=1 for 5 cycles during LOAD_SW -> exactly 5 extra cycles to done, beat count still 1024, stall_cnt=5 (macro defined) or 0 (undefined).
REQ-038 Scenario: sw_base=0xFFF0 -> addresses wrap to 0x0000 after 0xFFFF, no other effect.
REQ-039 Scenario: rst at cycle 30 -> cycle 31 all outputs 0, state IDLE; new start at 40 restarts at tb_base.
REQ-040 Scenario: start pulsed while busy -> ignored, single done only.
